sva_stim_gen: RTL and testbench
===============================

SVA_STIM_GEN -- requirements
Module: sva_stim_gen

Interface
REQ-001 SHALL have parameter PAT_DEPTH, default 8: number of pattern entries.
REQ-002 SHALL have parameter HOLD_W, default 4: width of the per-entry hold field.
REQ-003 SHALL have parameter LOOP_W, default 4: width of the loop-count field.
REQ-004 SHALL have parameter CYC_W, default 16: width of the cycle counter and the fault-cycle field.
REQ-005 gclk  in  1  user clock; all logic is on the rising edge.
REQ-006 grst  in  1  reset, asynchronous, active-high.
REQ-007 wr_en  in  1  pattern-memory write strobe.
REQ-008 wr_addr  in  clog2(PAT_DEPTH)  write address.
REQ-009 wr_data  in  1+HOLD_W  write data: {level, hold}; the entry drives level for hold+1 cycles.
REQ-010 num_entries  in  clog2(PAT_DEPTH)+1  count of active entries; sampled at start.
REQ-011 loops  in  LOOP_W  extra passes; pattern plays loops+1 times; sampled at start.
REQ-012 inject_en  in  1  enable single-cycle fault inversion; sampled at start.
REQ-013 inject_cycle  in  CYC_W  RUN-cycle index at which a is inverted; sampled at start.
REQ-014 start  in  1  launch request.
REQ-015 abort  in  1  terminate the run.
REQ-016 a  out  1  stimulus to the assertion checker (registered).
REQ-017 a_valid  out  1  high on every cycle a carries pattern data.
REQ-018 busy  out  1  high in RUN and DONE.
REQ-019 done  out  1  one-cycle pulse at completion or abort.
REQ-020 cycle_cnt  out  CYC_W  count of RUN cycles elapsed in the current or last run.

Function
REQ-021 SHALL implement FSM states IDLE, RUN, DONE; all outputs SHALL be registered.
REQ-022 IDLE: wr_en SHALL write wr_data to mem[wr_addr]; wr_addr >= PAT_DEPTH SHALL be ignored.
REQ-023 wr_en in RUN or DONE SHALL be ignored, leaving memory unchanged.
REQ-024 IDLE with start=1 at edge N SHALL latch the configuration, set entry index=0, hold counter=0, pass=0, cycle_cnt=0, and enter RUN.
REQ-025 On that launch, a=mem[0].level and a_valid=1 SHALL appear from edge N.
REQ-026 Exception to REQ-024: if num_entries=0 at start, the FSM SHALL go directly to DONE, with a_valid=0.
REQ-027 If num_entries>PAT_DEPTH, it SHALL be clamped to PAT_DEPTH.
REQ-028 RUN: each entry SHALL be driven for exactly hold+1 consecutive cycles, then advance to the next entry.
REQ-029 RUN: there SHALL be no idle gap between entries or between passes.
REQ-030 After the last cycle of entry num_entries-1: if pass<loops, pass SHALL increment and the index SHALL wrap to 0; otherwise the next state SHALL be DONE.
REQ-031 cycle_cnt SHALL increment once per RUN cycle after the first (first RUN cycle = index 0).
REQ-032 cycle_cnt SHALL saturate at all-ones without wrapping.
REQ-033 If inject_en is latched and the current RUN index equals inject_cycle, a SHALL equal the inverted level for that one cycle only.
REQ-034 If inject_cycle is beyond the run length, no inversion SHALL occur.
REQ-035 DONE SHALL last exactly one cycle with done=1, a=0, a_valid=0, busy=1, then go to IDLE.
REQ-036 abort in RUN SHALL go to DONE on the next edge (one-cycle done pulse), and a_valid SHALL drop on that edge.
REQ-037 abort takes priority over normal advance when both occur on the same edge.
REQ-038 abort in IDLE or DONE SHALL be ignored.
REQ-039 start while busy SHALL be ignored (no queuing).
REQ-040 In DONE, start SHALL also be ignored; a new run SHALL need start asserted in IDLE.
REQ-041 cycle_cnt SHALL hold its value in DONE and IDLE until the next start.

Reset
REQ-042 grst asserted SHALL immediately force: state=IDLE, a=0, a_valid=0, busy=0, done=0, cycle_cnt=0, internal counters=0, latched config=0.
REQ-043 Pattern memory SHALL NOT be reset and SHALL keep its contents across grst.
REQ-044 grst mid-run SHALL abort the run without a done pulse.
REQ-045 The first start after grst deasserts SHALL be accepted.

Verification
REQ-046 Write mem0={1,2}, mem1={0,0}; num_entries=2, loops=0; start -> a=1,1,1,0 with a_valid=1 for 4 cycles, then done pulse, cycle_cnt=3.
REQ-047 Same pattern, loops=2 -> 12 contiguous valid cycles repeating 1,1,1,0, no gaps; done once; cycle_cnt=11.
REQ-048 mem0={1,7}, num_entries=1, inject_en=1, inject_cycle=5 -> a=1 on all 8 cycles except index 5, where a=0.
REQ-049 num_entries=0 start -> next cycle done=1, a_valid never asserted; abort at RUN index 3 -> done on next edge, cycle_cnt=3.
REQ-050 grst pulsed at RUN index 2 -> outputs 0 asynchronously, no done pulse; memory intact, rerun reproduces REQ-046.
REQ-051 wr_en during RUN to mem0 -> ignored; start during RUN -> ignored; start on the cycle after done -> accepted.

Source files
------------

// File: rtl/sva_stim_gen.sv
// sva_stim_gen: pattern-driven stimulus generator for an assertion checker.
//
// A small pattern memory holds {level, hold} entries. On start, entries
// 0..num_entries-1 are replayed back to back, each driving `a` for hold+1
// cycles. The whole pattern repeats loops+1 times. Optionally one RUN cycle
// (counted from 0) has its level inverted to inject a fault.
//
// Ports:
//   gclk          clock, rising edge
//   grst          asynchronous active-high reset (pattern memory is kept)
//   wr_en/addr/data  pattern memory write, accepted only while idle
//   num_entries   active entry count (clamped to PAT_DEPTH), sampled at start
//   loops         extra passes, sampled at start
//   inject_en     enable single-cycle inversion, sampled at start
//   inject_cycle  RUN-cycle index to invert, sampled at start
//   start/abort   launch / terminate the run
//   a, a_valid    stimulus bit and its qualifier
//   busy          high in RUN and DONE
//   done          one-cycle pulse at completion or abort
//   cycle_cnt     RUN cycles elapsed (index of current cycle), saturating
module sva_stim_gen #(
  parameter int PAT_DEPTH = 8,
  parameter int HOLD_W    = 4,
  parameter int LOOP_W    = 4,
  parameter int CYC_W     = 16
) (
  input  logic                         gclk,
  input  logic                         grst,
  input  logic                         wr_en,
  input  logic [$clog2(PAT_DEPTH)-1:0] wr_addr,
  input  logic [HOLD_W:0]              wr_data,
  input  logic [$clog2(PAT_DEPTH):0]   num_entries,
  input  logic [LOOP_W-1:0]            loops,
  input  logic                         inject_en,
  input  logic [CYC_W-1:0]             inject_cycle,
  input  logic                         start,
  input  logic                         abort,
  output logic                         a,
  output logic                         a_valid,
  output logic                         busy,
  output logic                         done,
  output logic [CYC_W-1:0]             cycle_cnt
);

  localparam int AW = $clog2(PAT_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_reg;
  logic [HOLD_W:0]   mem [PAT_DEPTH];
  logic [AW-1:0]     idx_reg;
  logic [AW-1:0]     n_last_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic [LOOP_W-1:0] pass_reg;
  logic [LOOP_W-1:0] loops_reg;
  logic              inj_en_reg;
  logic [CYC_W-1:0]  inj_cycle_reg;
  logic [CYC_W-1:0]  cycle_reg;
  logic              a_reg;
  logic              a_valid_reg;
  logic              busy_reg;
  logic              done_reg;

  logic [AW:0]       n_clamped;
  logic [AW:0]       n_minus1;
  logic [HOLD_W:0]   cur_entry;
  logic [HOLD_W:0]   nxt_entry;
  logic [AW-1:0]     idx_next;
  logic              last_of_entry;
  logic              last_entry;
  logic              run_end;
  logic [CYC_W:0]    cyc_inc;
  logic              inj_next;
  logic [CYC_W-1:0]  cycle_next;

  // Pattern memory: no reset so contents survive grst; written only in IDLE.
  always_ff @(posedge gclk) begin
    if (wr_en && state_reg == IDLE && ({1'b0, wr_addr} < (AW+1)'(PAT_DEPTH)))
      mem[wr_addr] <= wr_data;
  end

  always_comb begin
    n_clamped     = (num_entries > (AW+1)'(PAT_DEPTH)) ? (AW+1)'(PAT_DEPTH) : num_entries;
    n_minus1      = n_clamped - (AW+1)'(1);
    cur_entry     = mem[idx_reg];
    last_of_entry = (hold_cnt_reg == cur_entry[HOLD_W-1:0]);
    last_entry    = (idx_reg == n_last_reg);
    idx_next      = last_entry ? '0 : idx_reg + AW'(1);
    nxt_entry     = mem[idx_next];
    run_end       = last_of_entry && last_entry && !(pass_reg < loops_reg);
    // Extra bit keeps a saturated counter from aliasing onto inject_cycle.
    cyc_inc       = {1'b0, cycle_reg} + (CYC_W+1)'(1);
    inj_next      = inj_en_reg && (cyc_inc == {1'b0, inj_cycle_reg});
    cycle_next    = (cycle_reg == '1) ? cycle_reg : cyc_inc[CYC_W-1:0];
  end

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      n_last_reg    <= '0;
      hold_cnt_reg  <= '0;
      pass_reg      <= '0;
      loops_reg     <= '0;
      inj_en_reg    <= 1'b0;
      inj_cycle_reg <= '0;
      cycle_reg     <= '0;
      a_reg         <= 1'b0;
      a_valid_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            n_last_reg    <= n_minus1[AW-1:0];
            loops_reg     <= loops;
            inj_en_reg    <= inject_en;
            inj_cycle_reg <= inject_cycle;
            idx_reg       <= '0;
            hold_cnt_reg  <= '0;
            pass_reg      <= '0;
            cycle_reg     <= '0;
            busy_reg      <= 1'b1;
            if (n_clamped == '0) begin
              // Empty pattern: straight to the completion pulse.
              state_reg   <= DONE;
              done_reg    <= 1'b1;
              a_reg       <= 1'b0;
              a_valid_reg <= 1'b0;
            end else begin
              state_reg   <= RUN;
              a_reg       <= mem[0][HOLD_W] ^ (inject_en && inject_cycle == '0);
              a_valid_reg <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort || run_end) begin
            state_reg   <= DONE;
            done_reg    <= 1'b1;
            a_reg       <= 1'b0;
            a_valid_reg <= 1'b0;
          end else begin
            cycle_reg <= cycle_next;
            if (last_of_entry) begin
              hold_cnt_reg <= '0;
              idx_reg      <= idx_next;
              if (last_entry)
                pass_reg <= pass_reg + LOOP_W'(1);
              a_reg <= nxt_entry[HOLD_W] ^ inj_next;
            end else begin
              hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
              a_reg        <= cur_entry[HOLD_W] ^ inj_next;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign a         = a_reg;
  assign a_valid   = a_valid_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign cycle_cnt = cycle_reg;

endmodule

// File: tb/tb_sva_stim_gen.sv
// Directed testbench for sva_stim_gen. A narrow cycle counter (CYC_W=5) is
// used so that saturation can be reached within a short run.
module tb_sva_stim_gen;

  localparam int PAT_DEPTH = 8;
  localparam int HOLD_W    = 4;
  localparam int LOOP_W    = 4;
  localparam int CYC_W     = 5;
  localparam int CYC_MAX   = 31;

  logic              gclk = 1'b0;
  logic              grst = 1'b1;
  logic              wr_en = 1'b0;
  logic [2:0]        wr_addr = '0;
  logic [HOLD_W:0]   wr_data = '0;
  logic [3:0]        num_entries = '0;
  logic [LOOP_W-1:0] loops = '0;
  logic              inject_en = 1'b0;
  logic [CYC_W-1:0]  inject_cycle = '0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              a;
  logic              a_valid;
  logic              busy;
  logic              done;
  logic [CYC_W-1:0]  cycle_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 gclk = ~gclk;

  sva_stim_gen #(
    .PAT_DEPTH(PAT_DEPTH), .HOLD_W(HOLD_W), .LOOP_W(LOOP_W), .CYC_W(CYC_W)
  ) dut (
    .gclk(gclk), .grst(grst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .num_entries(num_entries), .loops(loops), .inject_en(inject_en),
    .inject_cycle(inject_cycle), .start(start), .abort(abort), .a(a),
    .a_valid(a_valid), .busy(busy), .done(done), .cycle_cnt(cycle_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(negedge gclk);
  endtask

  task automatic wr(input int addr, input logic lvl, input int hold);
    wr_en   = 1'b1;
    wr_addr = 3'(addr);
    wr_data = {lvl, HOLD_W'(hold)};
    tick();
    wr_en   = 1'b0;
  endtask

  // Called at a negedge with start already driven high. Checks every RUN
  // cycle against pat, then the DONE cycle. dist_k >= 0 drives a memory
  // write and a second start during that RUN cycle; both must be ignored.
  task automatic run_seq(input string tag, input logic [63:0] pat, input int len,
                         input int dist_k);
    int exp_c;
    tick();
    start = 1'b0;
    for (int k = 0; k < len; k++) begin
      exp_c = (k > CYC_MAX) ? CYC_MAX : k;
      chk($sformatf("%s a[%0d]", tag, k), 32'(a), 32'(pat[k]));
      chk($sformatf("%s a_valid[%0d]", tag, k), 32'(a_valid), 32'd1);
      chk($sformatf("%s busy[%0d]", tag, k), 32'(busy), 32'd1);
      chk($sformatf("%s done[%0d]", tag, k), 32'(done), 32'd0);
      chk($sformatf("%s cycle_cnt[%0d]", tag, k), 32'(cycle_cnt), 32'(exp_c));
      if (k == dist_k) begin
        wr_en   = 1'b1;
        wr_addr = 3'd0;
        wr_data = '0;
        start   = 1'b1;
      end
      tick();
      wr_en = 1'b0;
      start = 1'b0;
    end
    exp_c = (len - 1 > CYC_MAX) ? CYC_MAX : len - 1;
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " done a"}, 32'(a), 32'd0);
    chk({tag, " done a_valid"}, 32'(a_valid), 32'd0);
    chk({tag, " done busy"}, 32'(busy), 32'd1);
    chk({tag, " done cycle_cnt"}, 32'(cycle_cnt), 32'(exp_c));
    $display("run %s: %0d cycles, cycle_cnt %0d, %0d miscompares so far", tag, len, cycle_cnt, n_miss);
  endtask

  task automatic idle_chk(input string tag, input int exp_c);
    tick();
    chk({tag, " idle done"}, 32'(done), 32'd0);
    chk({tag, " idle busy"}, 32'(busy), 32'd0);
    chk({tag, " idle cycle_cnt"}, 32'(cycle_cnt), 32'(exp_c));
  endtask

  logic [63:0] p;

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst a", 32'(a), 32'd0);
    chk("rst a_valid", 32'(a_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst cycle_cnt", 32'(cycle_cnt), 32'd0);
    grst = 1'b0;
    $display("reset released");

    wr(0, 1'b1, 2);
    wr(1, 1'b0, 0);

    // Basic two-entry pattern, single pass
    num_entries = 4'd2;
    loops = '0;
    start = 1'b1;
    run_seq("basic", 64'b0111, 4, -1);
    idle_chk("basic", 3);

    // Three passes, contiguous
    p = '0;
    for (int k = 0; k < 12; k++) p[k] = ((k % 4) != 3);
    loops = 4'd2;
    start = 1'b1;
    run_seq("loops2", p, 12, -1);
    idle_chk("loops2", 11);

    // Clamp num_entries above PAT_DEPTH: entries 2..7 low for one cycle each
    for (int i = 2; i < PAT_DEPTH; i++) wr(i, 1'b0, 0);
    num_entries = 4'd9;
    loops = '0;
    start = 1'b1;
    run_seq("clamp", 64'b0000000111, 10, -1);
    idle_chk("clamp", 9);

    // Fault injection at index 5
    wr(0, 1'b1, 7);
    num_entries = 4'd1;
    inject_en = 1'b1;
    inject_cycle = 5'd5;
    start = 1'b1;
    run_seq("inject5", 64'b11011111, 8, -1);
    idle_chk("inject5", 7);

    // Injection index beyond the run: no inversion
    inject_cycle = 5'd20;
    start = 1'b1;
    run_seq("inject_far", 64'hFF, 8, -1);
    idle_chk("inject_far", 7);
    inject_en = 1'b0;

    // Saturation: 48 RUN cycles with a 5-bit counter
    wr(0, 1'b1, 15);
    loops = 4'd2;
    start = 1'b1;
    run_seq("saturate", 64'hFFFF_FFFF_FFFF, 48, -1);
    idle_chk("saturate", CYC_MAX);

    // Empty pattern
    wr(0, 1'b1, 2);
    num_entries = 4'd0;
    loops = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("empty done", 32'(done), 32'd1);
    chk("empty a_valid", 32'(a_valid), 32'd0);
    chk("empty busy", 32'(busy), 32'd1);
    chk("empty cycle_cnt", 32'(cycle_cnt), 32'd0);
    idle_chk("empty", 0);
    chk("empty a_valid after", 32'(a_valid), 32'd0);
    $display("run empty: done pulse only");

    // Abort at RUN index 3
    num_entries = 4'd2;
    loops = 4'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("abort pre cycle_cnt", 32'(cycle_cnt), 32'd3);
    chk("abort pre a", 32'(a), 32'd0);
    chk("abort pre a_valid", 32'(a_valid), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort done", 32'(done), 32'd1);
    chk("abort a_valid", 32'(a_valid), 32'd0);
    chk("abort busy", 32'(busy), 32'd1);
    chk("abort cycle_cnt", 32'(cycle_cnt), 32'd3);
    idle_chk("abort", 3);
    $display("run abort: stopped at index 3");

    // grst mid-run at index 2
    loops = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("grst pre cycle_cnt", 32'(cycle_cnt), 32'd2);
    #2 grst = 1'b1;
    #1;
    chk("grst a", 32'(a), 32'd0);
    chk("grst a_valid", 32'(a_valid), 32'd0);
    chk("grst busy", 32'(busy), 32'd0);
    chk("grst cycle_cnt", 32'(cycle_cnt), 32'd0);
    tick();
    chk("grst done", 32'(done), 32'd0);
    grst = 1'b0;
    tick();
    chk("grst post done", 32'(done), 32'd0);
    chk("grst post busy", 32'(busy), 32'd0);
    $display("run grst: asynchronous clear");
    start = 1'b1;
    run_seq("rerun", 64'b0111, 4, -1);
    idle_chk("rerun", 3);

    // Write and start during RUN are ignored
    start = 1'b1;
    run_seq("disturb", 64'b0111, 4, 1);
    // start held in DONE is ignored; same start seen in IDLE is accepted
    start = 1'b1;
    tick();
    chk("done start busy", 32'(busy), 32'd0);
    chk("done start a_valid", 32'(a_valid), 32'd0);
    run_seq("memcheck", 64'b0111, 4, -1);
    idle_chk("memcheck", 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
